mem_stream_reader: RTL and testbench

Sequencer that sits directly upstream of the 32-bit word memory and turns it into a streamed source. On a start request it walks a contiguous address range (wrapping at the memory size), drives the memory read address, captures each combinationally-returned word into an output register and presents it on a valid/ready stream to the downstream compute datapath. Full throughput is one word per cycle when the consumer never stalls.

---
 rtl/mem_stream_reader.sv | 117 +++++++++++
 tb/tb_mem_stream_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Streams a contiguous (wrapping) range of a combinational-read word memory
// onto a valid/ready output, one word per cycle when the consumer never stalls.
module mem_stream_reader #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_MEM_SIZE = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_adr,
    input  logic [ADDR_WIDTH-1:0] count,
    output logic [ADDR_WIDTH-1:0] rd_adr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(MAX_MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   MEM_SIZE = (ADDR_WIDTH + 1)'(MAX_MEM_SIZE);

    state_e                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] rd_adr_q,    rd_adr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  err_q,       err_d;
    logic                  load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_adr_q    <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_adr_q    <= rd_adr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_adr_d    = rd_adr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        // Output register can take a new word when empty or being drained now.
        load        = !out_valid_q || out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ({1'b0, base_adr} >= MEM_SIZE) begin
                        err_d = 1'b1;
                    end else if (count == '0) begin
                        state_d = DONE;
                    end else begin
                        rd_adr_d    = base_adr;
                        remaining_d = count;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (load) begin
                    out_data_d  = rd_data;
                    out_valid_d = 1'b1;
                    remaining_d = remaining_q - ONE;
                    rd_adr_d    = (rd_adr_q == LAST_ADR) ? '0 : rd_adr_q + ONE;
                    if (remaining_q == ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_adr    = rd_adr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader against a mem[i]=i memory model.
module tb_mem_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_adr;
    logic [7:0]  count;
    logic [7:0]  rd_adr;
    logic [31:0] rd_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] mem [0:255];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_adr];

    mem_stream_reader #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .MAX_MEM_SIZE(128)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_adr (base_adr),
        .count    (count),
        .rd_adr   (rd_adr),
        .rd_data  (rd_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs the status outputs as {out_valid, busy, done, err}.
    function automatic logic [31:0] status();
        return {28'd0, out_valid, busy, done, err};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        rst = 1'b1; start = 1'b0; base_adr = '0; count = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_status", status(), 32'h0);
        check("rst_rd_adr", 32'(rd_adr), 32'd0);
        check("rst_data", out_data, 32'd0);
        rst = 1'b0;
        tick();

        // Basic transfer base=4 count=3, consumer always ready.
        start = 1'b1; base_adr = 8'd4; count = 8'd3; out_ready = 1'b1;
        tick(); start = 1'b0;
        check("s1_c1_status", status(), 32'b0100);
        check("s1_c1_adr", 32'(rd_adr), 32'd4);
        tick();
        check("s1_c2_status", status(), 32'b1100);
        check("s1_c2_data", out_data, 32'd4);
        tick();
        check("s1_c3_data", out_data, 32'd5);
        tick();
        check("s1_c4_data", out_data, 32'd6);
        check("s1_c4_adr", 32'(rd_adr), 32'd7);
        tick();
        check("s1_c5_status", status(), 32'b0110);
        tick();
        check("s1_c6_status", status(), 32'b0000);

        // Same transfer with ready pattern 1,0,0,1,1 from cycle 2.
        start = 1'b1; base_adr = 8'd4; count = 8'd3; out_ready = 1'b1;
        tick(); start = 1'b0;
        tick();
        out_ready = 1'b1;
        check("s2_c2", {out_valid, out_data[30:0]}, {1'b1, 31'd4});
        tick(); out_ready = 1'b0;
        check("s2_c3", {out_valid, out_data[30:0]}, {1'b1, 31'd5});
        tick(); out_ready = 1'b0;
        check("s2_c4_hold", {out_valid, out_data[30:0]}, {1'b1, 31'd5});
        check("s2_c4_adr", 32'(rd_adr), 32'd6);
        tick(); out_ready = 1'b1;
        check("s2_c5", {out_valid, out_data[30:0]}, {1'b1, 31'd5});
        tick(); out_ready = 1'b1;
        check("s2_c6", {out_valid, out_data[30:0]}, {1'b1, 31'd6});
        check("s2_c6_done", 32'(done), 32'd0);
        tick();
        check("s2_c7_status", status(), 32'b0110);
        tick();
        check("s2_c8_status", status(), 32'b0000);

        // Address wrap: base=126 count=4.
        start = 1'b1; base_adr = 8'd126; count = 8'd4; out_ready = 1'b1;
        tick(); start = 1'b0;
        check("s3_c1_adr", 32'(rd_adr), 32'd126);
        tick();
        check("s3_c2_data", out_data, 32'd126);
        check("s3_c2_adr", 32'(rd_adr), 32'd127);
        tick();
        check("s3_c3_data", out_data, 32'd127);
        check("s3_c3_adr", 32'(rd_adr), 32'd0);
        tick();
        check("s3_c4_data", out_data, 32'd0);
        tick();
        check("s3_c5_data", out_data, 32'd1);
        check("s3_c5_adr", 32'(rd_adr), 32'd2);
        tick();
        check("s3_c6_status", status(), 32'b0110);
        tick();

        // count==0 and out-of-range base.
        start = 1'b1; base_adr = 8'd9; count = 8'd0;
        tick(); start = 1'b0;
        check("s4_zero_c1", status(), 32'b0110);
        tick();
        check("s4_zero_c2", status(), 32'b0000);
        start = 1'b1; base_adr = 8'd200; count = 8'd5;
        tick(); start = 1'b0;
        check("s4_err_c1", status(), 32'b0001);
        tick();
        check("s4_err_c2", status(), 32'b0000);

        // Restart attempt mid-transfer is ignored.
        start = 1'b1; base_adr = 8'd10; count = 8'd3; out_ready = 1'b1;
        tick(); start = 1'b0;
        tick();
        start = 1'b1; base_adr = 8'd50; count = 8'd2;
        check("s5_c2_data", out_data, 32'd10);
        tick();
        check("s5_c3_data", out_data, 32'd11);
        start = 1'b0;
        tick();
        check("s5_c4_data", out_data, 32'd12);
        check("s5_c4_adr", 32'(rd_adr), 32'd13);
        tick();
        check("s5_c5_status", status(), 32'b0110);
        tick();
        check("s5_c6_status", status(), 32'b0000);

        // Reset during a stalled FETCH, then a fresh transfer.
        start = 1'b1; base_adr = 8'd4; count = 8'd3; out_ready = 1'b0;
        tick(); start = 1'b0;
        tick();
        check("s6_c2", {out_valid, out_data[30:0]}, {1'b1, 31'd4});
        tick();
        check("s6_c3_hold", {out_valid, out_data[30:0]}, {1'b1, 31'd4});
        check("s6_c3_adr", 32'(rd_adr), 32'd5);
        rst = 1'b1;
        tick();
        check("s6_rst_status", status(), 32'b0000);
        check("s6_rst_data", out_data, 32'd0);
        check("s6_rst_adr", 32'(rd_adr), 32'd0);
        rst = 1'b0;
        start = 1'b1; base_adr = 8'd4; count = 8'd3; out_ready = 1'b1;
        tick(); start = 1'b0;
        check("s6_f_c1_adr", 32'(rd_adr), 32'd4);
        tick();
        check("s6_f_c2_data", out_data, 32'd4);
        tick();
        check("s6_f_c3_data", out_data, 32'd5);
        tick();
        check("s6_f_c4_data", out_data, 32'd6);
        tick();
        check("s6_f_c5_status", status(), 32'b0110);
        tick();
        check("s6_f_c6_status", status(), 32'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
